// File: rtl/alu_exec_unit.sv
// Registered RV32I R-type execute stage: decodes funct7/funct3, applies the ALU op,
// and presents the result one cycle later with a valid flag and an illegal-decode flag.
module alu_exec_unit #(
  parameter int unsigned BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [31:0]          instr,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] c,
  output logic                 illegal
);

  localparam int unsigned SHAMT_W = $clog2(BIT_WIDTH);

  typedef enum logic [3:0] {
    ALU_ADD     = 4'd0,
    ALU_SUB     = 4'd1,
    ALU_SLL     = 4'd2,
    ALU_SLT     = 4'd3,
    ALU_SLTU    = 4'd4,
    ALU_XOR     = 4'd5,
    ALU_SRL     = 4'd6,
    ALU_SRA     = 4'd7,
    ALU_OR      = 4'd8,
    ALU_AND     = 4'd9,
    ALU_ILLEGAL = 4'd15
  } alu_funct_e;

  // Maps {funct7, funct3} to the internal ALU function code.
  function automatic alu_funct_e decode_funct(input logic [6:0] funct7,
                                              input logic [2:0] funct3);
    alu_funct_e op;
    op = ALU_ILLEGAL;
    case ({funct7, funct3})
      {7'b0000000, 3'b000}: op = ALU_ADD;
      {7'b0100000, 3'b000}: op = ALU_SUB;
      {7'b0000000, 3'b001}: op = ALU_SLL;
      {7'b0000000, 3'b010}: op = ALU_SLT;
      {7'b0000000, 3'b011}: op = ALU_SLTU;
      {7'b0000000, 3'b100}: op = ALU_XOR;
      {7'b0000000, 3'b101}: op = ALU_SRL;
      {7'b0100000, 3'b101}: op = ALU_SRA;
      {7'b0000000, 3'b110}: op = ALU_OR;
      {7'b0000000, 3'b111}: op = ALU_AND;
      default:              op = ALU_ILLEGAL;
    endcase
    return op;
  endfunction

  alu_funct_e           alu_funct_c;
  logic [SHAMT_W-1:0]   shamt_c;
  logic [BIT_WIDTH-1:0] result_c;
  logic                 illegal_c;

  logic [BIT_WIDTH-1:0] c_q, c_d;
  logic                 illegal_q, illegal_d;
  logic                 valid_q, valid_d;

  // Only the funct fields matter; the register specifiers and opcode are don't-care.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:0]};

  assign alu_funct_c = decode_funct(instr[31:25], instr[14:12]);
  assign shamt_c     = b[SHAMT_W-1:0];

  always_comb begin
    result_c  = '0;
    illegal_c = 1'b0;
    case (alu_funct_c)
      ALU_ADD:  result_c = a + b;
      ALU_SUB:  result_c = a - b;
      ALU_SLL:  result_c = a << shamt_c;
      ALU_SLT:  result_c = BIT_WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: result_c = BIT_WIDTH'(a < b);
      ALU_XOR:  result_c = a ^ b;
      ALU_SRL:  result_c = a >> shamt_c;
      ALU_SRA:  result_c = BIT_WIDTH'($signed(a) >>> shamt_c);
      ALU_OR:   result_c = a | b;
      ALU_AND:  result_c = a & b;
      default: begin
        result_c  = '0;
        illegal_c = 1'b1;
      end
    endcase
  end

  // Result and flag are captured only on a valid issue; otherwise they hold.
  always_comb begin
    c_d       = c_q;
    illegal_d = illegal_q;
    valid_d   = in_valid;
    if (in_valid) begin
      c_d       = result_c;
      illegal_d = illegal_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q       <= '0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      c_q       <= c_d;
      illegal_q <= illegal_d;
      valid_q   <= valid_d;
    end
  end

  assign c         = c_q;
  assign illegal   = illegal_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] c;
  logic        illegal;

  int n_cmp;
  int n_err;

  alu_exec_unit #(.BIT_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .instr     (instr),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .c         (c),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // R-type word with nonzero rd/rs1/rs2 fields so ignored bits are exercised.
  function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd7, 5'd19, f3, 5'd29, 7'b0110011};
  endfunction

  // Presents one operation before a rising edge, then returns 1 time unit after it.
  task automatic issue(input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    in_valid = 1'b1;
    instr    = mk_instr(f7, f3);
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    instr    = 32'hFFFF_FFFF;
    a        = 32'hDEAD_BEEF;
    b        = 32'h1234_5678;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    instr    = '0;
    a        = '0;
    b        = '0;
    #1;
    n_cmp++;
    if ({c, out_valid, illegal} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_init: c=%h out_valid=%b illegal=%b required c=0 out_valid=0 illegal=0",
               c, out_valid, illegal);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    issue(7'h00, 3'b000, 32'hFFFF_FFFF, 32'h1);
    n_cmp++;
    if (c !== 32'h0 || out_valid !== 1'b1 || illegal !== 1'b0) begin
      n_err++;
      $display("FAIL add_wrap: c=%h v=%b ill=%b required c=00000000 v=1 ill=0", c, out_valid, illegal);
    end
    issue(7'h20, 3'b000, 32'h0, 32'h1);
    n_cmp++;
    if (c !== 32'hFFFF_FFFF || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL sub_wrap: c=%h v=%b required c=ffffffff v=1", c, out_valid);
    end
  endtask

  task automatic test_compare();
    issue(7'h00, 3'b010, 32'hFFFF_FFFF, 32'h1);
    n_cmp++;
    if (c !== 32'h1) begin
      n_err++;
      $display("FAIL slt_neg: c=%h required 00000001", c);
    end
    issue(7'h00, 3'b011, 32'hFFFF_FFFF, 32'h1);
    n_cmp++;
    if (c !== 32'h0) begin
      n_err++;
      $display("FAIL sltu: c=%h required 00000000", c);
    end
    issue(7'h00, 3'b010, 32'h1, 32'hFFFF_FFFF);
    n_cmp++;
    if (c !== 32'h0) begin
      n_err++;
      $display("FAIL slt_pos: c=%h required 00000000", c);
    end
  endtask

  task automatic test_shift();
    issue(7'h00, 3'b101, 32'h8000_0000, 32'h24);
    n_cmp++;
    if (c !== 32'h0800_0000) begin
      n_err++;
      $display("FAIL srl: c=%h required 08000000", c);
    end
    issue(7'h20, 3'b101, 32'h8000_0000, 32'h24);
    n_cmp++;
    if (c !== 32'hF800_0000) begin
      n_err++;
      $display("FAIL sra_neg: c=%h required f8000000", c);
    end
    issue(7'h20, 3'b101, 32'h7000_0000, 32'h24);
    n_cmp++;
    if (c !== 32'h0700_0000) begin
      n_err++;
      $display("FAIL sra_pos: c=%h required 07000000", c);
    end
    issue(7'h20, 3'b101, 32'h8000_0000, 32'hFFFF_FFFF);
    n_cmp++;
    if (c !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL sra_31: c=%h required ffffffff", c);
    end
    issue(7'h00, 3'b001, 32'h1, 32'h24);
    n_cmp++;
    if (c !== 32'h10) begin
      n_err++;
      $display("FAIL sll: c=%h required 00000010", c);
    end
  endtask

  task automatic test_illegal();
    issue(7'h20, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_cmp++;
    if (c !== 32'h0 || illegal !== 1'b1 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_f7_20: c=%h ill=%b v=%b required c=0 ill=1 v=1", c, illegal, out_valid);
    end
    issue(7'h00, 3'b111, 32'h0000_F0F0, 32'h0000_FF00);
    n_cmp++;
    if (c !== 32'h0000_F000 || illegal !== 1'b0) begin
      n_err++;
      $display("FAIL and_after_illegal: c=%h ill=%b required c=0000f000 ill=0", c, illegal);
    end
    issue(7'h01, 3'b000, 32'h5, 32'h6);
    n_cmp++;
    if (c !== 32'h0 || illegal !== 1'b1) begin
      n_err++;
      $display("FAIL illegal_f7_01: c=%h ill=%b required c=0 ill=1", c, illegal);
    end
  endtask

  task automatic test_back_to_back();
    issue(7'h00, 3'b100, 32'hA5A5_A5A5, 32'hFFFF_0000);
    n_cmp++;
    if (c !== 32'h5A5A_A5A5 || out_valid !== 1'b1 || illegal !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_xor: c=%h v=%b ill=%b required c=5a5aa5a5 v=1 ill=0", c, out_valid, illegal);
    end
    issue(7'h00, 3'b110, 32'h0F00_00F0, 32'h0000_F00F);
    n_cmp++;
    if (c !== 32'h0F00_F0FF || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_or: c=%h v=%b required c=0f00f0ff v=1", c, out_valid);
    end
    idle();
    n_cmp++;
    if (out_valid !== 1'b0 || c !== 32'h0F00_F0FF || illegal !== 1'b0) begin
      n_err++;
      $display("FAIL hold_1: c=%h v=%b ill=%b required c=0f00f0ff v=0 ill=0", c, out_valid, illegal);
    end
    idle();
    n_cmp++;
    if (out_valid !== 1'b0 || c !== 32'h0F00_F0FF) begin
      n_err++;
      $display("FAIL hold_2: c=%h v=%b required c=0f00f0ff v=0", c, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    issue(7'h00, 3'b000, 32'h0000_1000, 32'h0000_0234);
    n_cmp++;
    if (c !== 32'h0000_1234 || out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_add: c=%h v=%b required c=00001234 v=1", c, out_valid);
    end
    // Assert reset between edges; outputs must clear before the next edge.
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({c, out_valid, illegal} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_async: c=%h v=%b ill=%b required all 0", c, out_valid, illegal);
    end
    in_valid = 1'b1;
    instr    = mk_instr(7'h00, 3'b110);
    a        = 32'hFFFF_FFFF;
    b        = 32'h0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({c, out_valid, illegal} !== 34'h0) begin
      n_err++;
      $display("FAIL reset_held: c=%h v=%b ill=%b required all 0", c, out_valid, illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    issue(7'h00, 3'b111, 32'h0000_F0F0, 32'h0000_FF00);
    n_cmp++;
    if (c !== 32'h0000_F000 || out_valid !== 1'b1 || illegal !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_and: c=%h v=%b ill=%b required c=0000f000 v=1 ill=0", c, out_valid, illegal);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_arith();
    test_compare();
    test_shift();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Registered integer execute stage for the Philosophy V core. Decodes the funct3/funct7 fields of an RV32I R-type instruction into an internal ALU function code, applies that function to two BIT_WIDTH-bit operands, and registers the result with a valid flag. It sits between operand fetch and writeback, replacing the combinational decoder-plus-ALU pair inside the core.

## Interface
- BIT_WIDTH, 32: operand and result width. Must be a power of two, 8 or greater.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instr/a/b are valid this cycle.
- instr  input  32  instruction word. Only funct3 = instr[14:12] and funct7 = instr[31:25] are used; all other bits are ignored.
- a  input  BIT_WIDTH  operand x (rs1 value).
- b  input  BIT_WIDTH  operand y (rs2 value).
- out_valid  output  1  c and illegal hold a new result.
- c  output  BIT_WIDTH  registered result.
- illegal  output  1  the captured funct3/funct7 pair was unsupported.

## Operation
- Decoder: a combinational function maps {funct7, funct3} to a 4-bit alu_funct code.
- Supported pairs (funct7, funct3 -> op):

| funct7 | funct3 | op | result |
|---|---|---|---|
| 0000000 | 000 | ADD | a + b, modulo 2^BIT_WIDTH |
| 0100000 | 000 | SUB | a − b, modulo 2^BIT_WIDTH |
| 0000000 | 001 | SLL | a << b[log2(BIT_WIDTH)−1:0] |
| 0000000 | 010 | SLT | 1 if a < b as signed, else 0; zero-extended |
| 0000000 | 011 | SLTU | 1 if a < b as unsigned, else 0; zero-extended |
| 0000000 | 100 | XOR | a ^ b |
| 0000000 | 101 | SRL | a >> shamt, zero fill |
| 0100000 | 101 | SRA | a >> shamt, sign fill from a[BIT_WIDTH−1] |
| 0000000 | 110 | OR | a \| b |
| 0000000 | 111 | AND | a & b |

- Shifts (SLL, SRL, SRA) use only the low log2(BIT_WIDTH) bits of b as the shift amount (shamt); the upper bits of b are ignored.
- Any other {funct7, funct3} pair decodes to ILLEGAL. ILLEGAL produces c = 0 and illegal = 1.
- No overflow or carry flags are produced; arithmetic wraps.

## Timing
- Reset: while rst_n = 0, and immediately on its falling edge, c = 0, out_valid = 0, illegal = 0, regardless of clk.
- Latency is 1 cycle. If in_valid = 1 at rising edge N, then after edge N:
  - c is the result for the inputs sampled at edge N;
  - illegal reflects the decode of that instr;
  - out_valid = 1.
- If in_valid = 0 at a rising edge:
  - out_valid = 0 after that edge;
  - c and illegal hold their previous values.
- Throughput is one operation per cycle; back-to-back in_valid is fully supported.
- There is no stall or back-pressure input.
- Reset asserted mid-stream discards the in-flight result. The first edge after reset release with in_valid = 1 produces normal output.
- No combinational path exists from any input to any output.

## Test plan
- Reset: drive rst_n = 0 mid-operation with c = 0x1234 held -> c, out_valid and illegal go to 0 immediately, without waiting for a clock edge.
- Arithmetic:
  - ADD: a = 0xFFFFFFFF, b = 1 -> c = 0 one cycle later, out_valid = 1.
  - SUB (funct7 = 0x20): a = 0, b = 1 -> c = 0xFFFFFFFF.
- Compares: a = 0xFFFFFFFF, b = 1:
  - SLT -> c = 1;
  - SLTU -> c = 0.
- Shifts: a = 0x80000000, b = 0x24 (shamt 4):
  - SRL -> c = 0x08000000;
  - SRA -> c = 0xF8000000;
  - SLL with a = 1 -> c = 0x10.
- Illegal decode: funct7 = 0x20 with funct3 = 111 -> c = 0, illegal = 1, out_valid = 1. A following legal AND with a = 0xF0F0, b = 0xFF00 -> c = 0xF000, illegal = 0.
- Hold and streaming:
  - Back-to-back XOR and OR on consecutive cycles each appear one cycle after issue.
  - Dropping in_valid -> out_valid = 0 while c holds the last result.
